// File: rtl/conv_requant_pack.sv
// conv_requant_pack: requantises 24-bit signed conv results to int8, packs four
// bytes little-endian into 32-bit words and queues them in a show-ahead FIFO.
// Build option: define CONV_REQUANT_ROUND_EN for round-half-up shifting;
// without it the shift truncates (floor toward minus infinity).
module conv_requant_pack #(
    parameter int IN_W  = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     relu_en,
    input  logic [4:0]               shift_amt,
    input  logic                     flush,
    input  logic                     clear,
    input  logic                     rd_en,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               lane,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(127);
    localparam logic signed [IN_W:0] SAT_MIN = (IN_W+1)'(-128);

    // Stage 1 state
    logic               s1_valid_q;
    logic               flush_q;
    logic [7:0]         byte_q;
    logic [7:0]         byte_d;

    // Packer state
    logic [1:0]         lane_q, lane_d;
    logic [31:0]        word_q, word_d;
    logic               push;
    logic [31:0]        push_word;

    // FIFO state
    logic [31:0]        mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic               overflow_q;
    logic               pop;
    logic               fifo_full;
    logic               wr_ok;

    // Requant datapath
    logic [4:0]         s;
    logic signed [IN_W:0] x_ext;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] y;

    // ReLU, clamp the shift, shift (rounded or truncated) and saturate to int8.
    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        s     = (shift_amt > 5'd23) ? 5'd23 : shift_amt;
        x_ext = $signed({in_data[IN_W-1], in_data});
        if (relu_en && in_data[IN_W-1]) begin
            x_ext = '0;
        end
`ifdef CONV_REQUANT_ROUND_EN
        if (s != 5'd0) begin
            sum = x_ext + $signed((IN_W+1)'(1) << (s - 5'd1));
        end else begin
            sum = x_ext;
        end
`else
        sum = x_ext;
`endif
        y = sum >>> s;
        if (y > SAT_MAX) begin
            byte_d = 8'h7F;
        end else if (y < SAT_MIN) begin
            byte_d = 8'h80;
        end else begin
            byte_d = y[7:0];
        end
    end

    // Stage 1 control: byte valid and flush delayed together; clear drops both.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s1_valid_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            flush_q    <= flush;
        end
    end

    // Stage 1 data register; qualified by s1_valid_q so it needs no reset.
    always_ff @(posedge clk) begin
        byte_q <= byte_d;
    end

    // Packer: merge the byte first, then let flush emit whatever remains, so a
    // fourth byte coinciding with flush yields exactly one word.
    always_comb begin
        word_d    = word_q;
        lane_d    = lane_q;
        push      = 1'b0;
        push_word = word_q;
        if (s1_valid_q) begin
            push_word[{lane_q, 3'b000} +: 8] = byte_q;
            if (lane_q == 2'd3) begin
                push   = 1'b1;
                lane_d = 2'd0;
                word_d = '0;
            end else begin
                lane_d = lane_q + 2'd1;
                word_d = push_word;
            end
        end
        if (flush_q && (lane_d != 2'd0)) begin
            push      = 1'b1;
            push_word = word_d;
            lane_d    = 2'd0;
            word_d    = '0;
        end
    end

    assign pop       = rd_en && (count_q != '0);
    assign fifo_full = (count_q == CW'(DEPTH));
    assign wr_ok     = push && (!fifo_full || pop);

    // FIFO storage write; contents are not reset, reads are gated when empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    // Packer and FIFO bookkeeping; overflow is sticky until rst or clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane_q     <= 2'd0;
            word_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(wr_ok) - CW'(pop);
            if (push && !wr_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign rd_data  = (count_q != '0) ? mem[rd_ptr_q] : 32'h0;
    assign rd_valid = (count_q != '0);
    assign full     = fifo_full;
    assign count    = count_q;
    assign lane     = lane_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_conv_requant_pack.sv
// Testbench for conv_requant_pack: scoreboard of expected words filled by the
// stimulus side, drained by a negedge monitor whenever a word is popped.
module tb_conv_requant_pack;

    localparam int IN_W  = 24;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [IN_W-1:0]   in_data = '0;
    logic              relu_en = 1'b0;
    logic [4:0]        shift_amt = '0;
    logic              flush = 1'b0;
    logic              clear = 1'b0;
    logic              rd_en = 1'b0;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic              full;
    logic [$clog2(DEPTH):0] count;
    logic [1:0]        lane;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    int unsigned exp_q[$];
    int          m_bytes[$];
    bit          exp_overflow = 1'b0;
    bit          coincide_pop = 1'b0;

    conv_requant_pack #(.IN_W(IN_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .relu_en(relu_en), .shift_amt(shift_amt), .flush(flush),
        .clear(clear), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .count(count), .lane(lane), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic longint floor_div(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int ref_byte(int x, bit relu, int sh);
        int     s;
        longint v;
        longint yv;
        s = (sh > 23) ? 23 : sh;
        v = x;
        if (relu && v < 0) v = 0;
`ifdef CONV_REQUANT_ROUND_EN
        if (s > 0) yv = floor_div(v + (longint'(1) << (s - 1)), longint'(1) << s);
        else       yv = v;
`else
        yv = floor_div(v, longint'(1) << s);
`endif
        if (yv > 127)  yv = 127;
        if (yv < -128) yv = -128;
        return int'(yv);
    endfunction

    function automatic void push_word(int unsigned w);
        if (exp_q.size() >= DEPTH && !coincide_pop) exp_overflow = 1'b1;
        else exp_q.push_back(w);
    endfunction

    function automatic int unsigned pack_bytes();
        int unsigned w;
        w = 0;
        foreach (m_bytes[i]) w = w | (int'(m_bytes[i] & 255) << (8 * i));
        return w;
    endfunction

    function automatic void model_byte(int b);
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
            push_word(pack_bytes());
            m_bytes.delete();
        end
    endfunction

    function automatic void model_flush();
        if (m_bytes.size() > 0) begin
            push_word(pack_bytes());
            m_bytes.delete();
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        m_bytes.delete();
        exp_overflow = 1'b0;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit v, input int d, input bit relu, input int sh,
                       input bit fl, input bit rd);
        in_valid  = v;
        in_data   = d[IN_W-1:0];
        relu_en   = relu;
        shift_amt = sh[4:0];
        flush     = fl;
        rd_en     = rd;
        clear     = 1'b0;
        rst       = 1'b0;
        if (v)  model_byte(ref_byte(d, relu, sh));
        if (fl) model_flush();
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; flush = 1'b0; rd_en = 1'b0; clear = 1'b0; rst = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_clear();
        in_valid = 1'b1; in_data = 24'h000123; flush = 1'b1; rd_en = 1'b0;
        clear = 1'b1;
        model_clear();
        tick();
        idle(0);
    endtask

    task automatic drain();
        int n;
        idle(2);
        n = 0;
        rd_en = 1'b1;
        while (rd_valid && n < 64) begin
            tick();
            n++;
        end
        rd_en = 1'b0;
        if (rd_valid) chk("drain_timeout", 1, 0);
        tick();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        int unsigned w;
        if (rd_en && rd_valid && !rst && !clear) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %08h expected no word", rd_data);
            end else begin
                w = exp_q.pop_front();
                if (rd_data !== w) begin
                    errors++;
                    $display("FAIL pop_word: got %08h expected %08h", rd_data, w);
                end else begin
                    $display("ok   pop_word: %08h", rd_data);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int unsigned spec_word;
        int d;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_rd_data", rd_data, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_full", full, 0);
        chk("reset_count", count, 0);
        chk("reset_lane", lane, 0);
        chk("reset_overflow", overflow, 0);

        // Round/saturate word and rd_valid latency
        cyc(1, 40, 0, 4, 0, 0);
        cyc(1, -40, 0, 4, 0, 0);
        cyc(1, 5000, 0, 4, 0, 0);
        cyc(1, -5000, 0, 4, 0, 0);
        idle(0);
        chk("latency_not_yet", rd_valid, 0);
        tick();
        chk("latency_valid", rd_valid, 1);
`ifdef CONV_REQUANT_ROUND_EN
        spec_word = 32'h807FFE03;
`else
        spec_word = 32'h807FFD02;
`endif
        chk("round_sat_word", rd_data, spec_word);
        drain();

        // ReLU
        cyc(1, -7, 1, 0, 0, 0);
        cyc(1, 9, 1, 0, 0, 0);
        cyc(1, -1, 1, 0, 0, 0);
        cyc(1, 200, 1, 0, 0, 0);
        idle(2);
        spec_word = 32'h7F000900;
        chk("relu_word", rd_data, spec_word);
        drain();

        // Flush partial word, flush on empty lane, flush with fourth byte
        cyc(1, 'h11, 0, 0, 0, 0);
        cyc(1, 'h22, 0, 0, 0, 0);
        idle(1);
        chk("flush_lane_before", lane, 2);
        cyc(0, 0, 0, 0, 1, 0);
        idle(1);
        chk("flush_lane_after", lane, 0);
        chk("flush_count", count, 1);
        spec_word = 32'h00002211;
        chk("flush_word", rd_data, spec_word);
        cyc(0, 0, 0, 0, 1, 0);
        idle(2);
        chk("flush_empty_noop", count, 1);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 2, 0, 0, 0, 0);
        cyc(1, 3, 0, 0, 0, 0);
        cyc(1, 4, 0, 0, 1, 0);
        idle(2);
        chk("flush_coincident_count", count, 2);
        chk("flush_coincident_lane", lane, 0);
        drain();

        // Overflow: DEPTH+1 words without reads
        for (int k = 1; k <= 4 * (DEPTH + 1); k++) cyc(1, k, 0, 0, 0, 0);
        idle(2);
        chk("ovf_count", count, DEPTH);
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, exp_overflow);
        // push and pop in the same edge while full
        cyc(1, 100, 0, 0, 0, 0);
        cyc(1, 101, 0, 0, 0, 0);
        cyc(1, 102, 0, 0, 0, 0);
        coincide_pop = 1'b1;
        cyc(1, 103, 0, 0, 0, 0);
        coincide_pop = 1'b0;
        cyc(0, 0, 0, 0, 0, 1);
        idle(1);
        chk("full_pushpop_count", count, DEPTH);
        chk("full_pushpop_ovf", overflow, 1);
        drain();
        chk("ovf_drained_count", count, 0);

        // Clear mid-word
        do_clear();
        chk("clear_overflow", overflow, 0);
        cyc(1, 50, 0, 0, 0, 0);
        cyc(1, 51, 0, 0, 0, 0);
        cyc(1, 52, 0, 0, 0, 0);
        do_clear();
        idle(1);
        chk("clear_lane", lane, 0);
        chk("clear_count", count, 0);
        chk("clear_overflow2", overflow, 0);
        cyc(1, 60, 0, 0, 0, 0);
        cyc(1, 61, 0, 0, 0, 0);
        cyc(1, 62, 0, 0, 0, 0);
        cyc(1, 63, 0, 0, 0, 0);
        idle(2);
        chk("clear_next_count", count, 1);
        drain();

        // Reset mid-stream
        for (int k = 0; k < 14; k++) cyc(1, k + 7, 0, 0, 0, 0);
        idle(2);
        chk("pre_reset_count", count, 3);
        in_valid = 1'b1; rd_en = 1'b0; rst = 1'b1;
        model_clear();
        tick();
        idle(0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_lane", lane, 0);
        chk("rst_overflow", overflow, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("rst_rden_empty_count", count, 0);
        chk("rst_rden_empty_valid", rd_valid, 0);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 1) == 1)
                d = int'($urandom_range(0, 16777215)) - 8388608;
            else
                d = int'($urandom_range(0, 600)) - 300;
            cyc(($urandom_range(0, 3) != 0), d, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) != 0));
        end
        cyc(0, 0, 0, 0, 1, 0);
        drain();
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_count", count, 0);
        chk("final_overflow", overflow, exp_overflow);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
